// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 8-bit synchronous memory port: core vs host,
// round-robin with a host burst lock, a core starvation guard and read-response routing.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam logic       OWNER_CORE = 1'b0;
  localparam logic       OWNER_HOST = 1'b1;
  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);
  localparam logic [7:0] LOCK_SAT   = 8'hFF;

  logic       last;
  logic [7:0] lock_cnt;
  logic       rv_core;
  logic       rv_host;

  // Grants are held low throughout reset so nothing reaches the macro mid-reset.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      if (core_req && host_req) begin
        if (host_lock && (last == OWNER_HOST) && (lock_cnt < LOCK_LIMIT)) begin
          host_gnt = 1'b1;
        end else if (lock_cnt == LOCK_LIMIT) begin
          core_gnt = 1'b1;
        end else if (last == OWNER_HOST) begin
          core_gnt = 1'b1;
        end else begin
          host_gnt = 1'b1;
        end
      end else begin
        core_gnt = core_req;
        host_gnt = host_req;
      end
    end
  end

  // Idle cycles drive zeros so the macro pins never toggle without a strobe.
  always_comb begin
    mem_en    = core_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last     <= OWNER_HOST;
      lock_cnt <= '0;
      rv_core  <= 1'b0;
      rv_host  <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
      if (core_gnt) begin
        last <= OWNER_CORE;
      end else if (host_gnt) begin
        last <= OWNER_HOST;
      end

      // Counts only host grants that actually made the core wait.
      if (core_gnt || !core_req) begin
        lock_cnt <= '0;
      end else if (host_gnt && (lock_cnt != LOCK_SAT)) begin
        lock_cnt <= lock_cnt + 8'd1;
      end

      rv_core <= core_gnt & ~core_we;
      rv_host <= host_gnt & ~host_we;
    end
  end

  assign core_rvalid = rv_core;
  assign host_rvalid = rv_host;
  assign rdata       = mem_rdata;
  assign owner       = last;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model on the port.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              core_req, core_we, host_req, host_we, host_lock;
  logic [ADDR_W-1:0] core_addr, host_addr;
  logic [DATA_W-1:0] core_wdata, host_wdata;
  logic              core_gnt, core_rvalid, host_gnt, host_rvalid;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_en, mem_we, owner;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(3)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 8'h5A;
    mem[8'h30] = 8'h3C;
    idle_inputs();
    reset = 1'b1;

    // Reset values
    #1;
    check("rst_owner", owner, 1);
    check("rst_core_rvalid", core_rvalid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    #11 reset = 1'b0;
    tick();

    // Uncontended core read of 0x10
    core_req = 1; core_we = 0; core_addr = 8'h10;
    #1;
    check("cr_core_gnt", core_gnt, 1);
    check("cr_host_gnt", host_gnt, 0);
    check("cr_mem_en", mem_en, 1);
    check("cr_mem_addr", mem_addr, 8'h10);
    tick();
    core_req = 0;
    check("cr_core_rvalid", core_rvalid, 1);
    check("cr_rdata", rdata, 8'h5A);
    check("cr_host_rvalid", host_rvalid, 0);
    check("cr_owner", owner, 0);

    // Uncontended host read of 0x30 leaves last = host
    host_req = 1; host_we = 0; host_addr = 8'h30;
    #1;
    check("hr_host_gnt", host_gnt, 1);
    check("hr_core_gnt", core_gnt, 0);
    tick();
    host_req = 0;
    check("hr_host_rvalid", host_rvalid, 1);
    check("hr_rdata", rdata, 8'h3C);
    check("hr_owner", owner, 1);

    // Contention without lock: core, host, core, host, core, host
    core_req = 1; core_we = 0; core_addr = 8'h10;
    host_req = 1; host_we = 0; host_addr = 8'h30;
    for (int i = 0; i < 6; i++) begin
      logic exp_core;
      exp_core = (i % 2 == 0);
      #1;
      check($sformatf("rr_core_gnt%0d", i), core_gnt, exp_core);
      check($sformatf("rr_host_gnt%0d", i), host_gnt, !exp_core);
      tick();
      check($sformatf("rr_core_rv%0d", i), core_rvalid, exp_core);
      check($sformatf("rr_host_rv%0d", i), host_rvalid, !exp_core);
      check($sformatf("rr_rdata%0d", i), rdata, exp_core ? 8'h5A : 8'h3C);
    end

    // Idle bus with junk on the request fields
    idle_inputs();
    core_addr = 8'h10; core_wdata = 8'hFF; core_we = 1;
    host_addr = 8'h30; host_wdata = 8'hEE; host_we = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("idle_mem_en%0d", i), mem_en, 0);
      check($sformatf("idle_mem_we%0d", i), mem_we, 0);
      check($sformatf("idle_mem_addr%0d", i), mem_addr, 0);
      check($sformatf("idle_mem_wdata%0d", i), mem_wdata, 0);
      tick();
      check($sformatf("idle_owner%0d", i), owner, 1);
      check($sformatf("idle_lock_cnt%0d", i), dut.lock_cnt, 0);
    end

    // Locked host burst with MAX_LOCK = 3: H H H C H H H C
    begin
      int h;
      h = 0;
      idle_inputs();
      core_req = 1; core_we = 0; core_addr = 8'h10;
      host_req = 1; host_we = 1; host_lock = 1;
      for (int i = 0; i < 8; i++) begin
        logic exp_core;
        exp_core = (i == 3 || i == 7);
        host_addr  = 8'(h);
        host_wdata = 8'(8'h80 + h);
        #1;
        check($sformatf("lk_core_gnt%0d", i), core_gnt, exp_core);
        check($sformatf("lk_host_gnt%0d", i), host_gnt, !exp_core);
        check($sformatf("lk_mem_we%0d", i), mem_we, !exp_core);
        check($sformatf("lk_mem_addr%0d", i), mem_addr, exp_core ? 8'h10 : 8'(h));
        tick();
        check($sformatf("lk_core_rv%0d", i), core_rvalid, exp_core);
        check($sformatf("lk_host_rv%0d", i), host_rvalid, 0);
        if (!exp_core) h++;
      end
    end
    idle_inputs();

    // Host write 0xA5 to 0x20 and core read 0x20 together, last = core
    core_req = 1; core_we = 0; core_addr = 8'h20;
    host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'hA5;
    #1;
    check("wr_host_gnt", host_gnt, 1);
    check("wr_core_gnt", core_gnt, 0);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_wdata", mem_wdata, 8'hA5);
    tick();
    host_req = 0;
    #1;
    check("wr_core_gnt2", core_gnt, 1);
    check("wr_mem_addr2", mem_addr, 8'h20);
    tick();
    core_req = 0;
    check("wr_core_rv", core_rvalid, 1);
    check("wr_rdata", rdata, 8'hA5);

    // Host write from the locked burst landed in memory
    host_req = 1; host_we = 0; host_addr = 8'h02;
    tick();
    host_req = 0;
    check("lkmem_rv", host_rvalid, 1);
    check("lkmem_rdata", rdata, 8'h82);

    // Lock drop mid-burst: last = host, lock held once more, then round-robin
    core_req = 1; core_we = 1; core_addr = 8'h40; core_wdata = 8'h11;
    host_req = 1; host_we = 1; host_addr = 8'h41; host_wdata = 8'h22; host_lock = 1;
    #1;
    check("ld_host_gnt0", host_gnt, 1);
    tick();
    host_lock = 0;
    #1;
    check("ld_core_gnt1", core_gnt, 1);
    tick();
    #1;
    check("ld_host_gnt2", host_gnt, 1);
    tick();
    idle_inputs();

    // Reset asserted between edges while a read response is pending
    core_req = 1; core_we = 0; core_addr = 8'h10;
    tick();
    check("ra_core_rv_before", core_rvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("ra_core_gnt", core_gnt, 0);
    check("ra_core_rv", core_rvalid, 0);
    check("ra_host_rv", host_rvalid, 0);
    check("ra_owner", owner, 1);
    check("ra_mem_en", mem_en, 0);
    tick();
    check("ra_core_rv_held", core_rvalid, 0);
    #2 reset = 1'b0;
    #1;
    check("ra_release_gnt", core_gnt, 1);
    tick();
    check("ra_release_rv", core_rvalid, 1);
    check("ra_release_rdata", rdata, 8'h5A);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
